karat_div: RTL
==============

Name: karat_div

Overview:
- Sequential restoring divider, radix-2, one quotient bit per clock. It is the inverse datapath of the karat_mult product path.
- Takes a wO-bit dividend (typically a karat_mult product) and a wI-bit divisor. Returns a wI-bit quotient, a wI-bit remainder and an overflow flag.
- Used to check and undo products: for any X, Y with Y != 0, dividing X*Y by Y returns quotient X and remainder 0.

Parameters:
- wI, 64, divisor/quotient/remainder width.
- wO, 2*wI, dividend width. Must equal 2*wI. Not overridden independently.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iValid  input  1  dividend/divisor valid.
- oReady  output  1  block can accept an operand pair.
- iO  input  wO  dividend.
- iY  input  wI  divisor.
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts the result.
- oQ  output  wI  quotient.
- oR  output  wI  remainder.
- oOvf  output  1  quotient does not fit in wI bits, or divisor is zero.

Behaviour:
- Reset (iRstN low, asynchronous):
  - State goes to IDLE.
  - oValid=0, oQ=0, oR=0, oOvf=0, oReady=1 (it is decoded from IDLE).
  - Iteration counter is cleared.
  - Reset during CALC or DONE aborts the operation; the result is discarded and never presented.
- States: IDLE, CALC, DONE.
- IDLE:
  - oReady=1.
  - Accept occurs on an edge where iValid=1.
  - On accept, latch iY into the divisor register.
  - Overflow check on accept: iY==0 or iO[wO-1:wI] >= iY. If true, go to DONE with oOvf=1, oQ=all ones, oR=0. Latency is 1 edge.
  - Otherwise load partial remainder P = {1'b0, iO[wO-1:wI]} (wI+1 bits) and shift register S = iO[wI-1:0]. Set counter to 0 and go to CALC.
- CALC (oReady=0), each edge:
  - T = {P[wI-1:0], S[wI-1]}.
  - If T >= {1'b0, Y}: P = T - Y and shift S left inserting 1. Otherwise P = T and shift S left inserting 0.
  - Counter increments. After the wI-th CALC edge: oQ=S, oR=P[wI-1:0], oOvf=0, go to DONE.
- Latency from the accept edge to oValid=1 is wI+1 edges for a normal divide and 1 edge for overflow.
- DONE:
  - oValid=1, oReady=0.
  - oQ, oR and oOvf are held stable while iReady=0, for any number of cycles.
  - On an edge with iReady=1: oValid=0, go to IDLE.
- Throughput:
  - At most one operation in flight.
  - The next accept is possible on the edge after the result handshake.
  - iValid and iO/iY are ignored outside IDLE; no input buffering.
- Outputs are registered and hold their last value after returning to IDLE until the next result is written.
- Arithmetic invariant, non-overflow case: iO == oQ*iY + oR, and oR < iY.
- The counter is sized ceil(log2(wI))+1 bits. It has no wrap-around dependency.

Test Plan:
- Basic divide, wI=8: accept iO=16'd100, iY=8'd7 -> oValid=1 exactly 9 edges after accept, oQ=14, oR=2, oOvf=0.
- Overflow and divide-by-zero, wI=8:
  - iO=16'h0700, iY=7 -> oValid after 1 edge, oOvf=1, oQ=8'hFF, oR=0.
  - iO=16'h1234, iY=0 -> same response.
- Boundary, wI=8:
  - iO=16'hFE01, iY=8'hFF -> oQ=8'hFF, oR=0, oOvf=0.
  - iO=16'h00FF, iY=1 -> oQ=8'hFF, oR=0.
- Backpressure: hold iReady=0 for 20 cycles after oValid -> oValid, oQ, oR, oOvf unchanged every cycle; oReady=0 throughout. iReady=1 -> oValid drops on the next edge and oReady=1.
- Reset mid-operation: drop iRstN at CALC iteration 3 -> oValid=0, oQ=oR=0, oReady=1 immediately (asynchronous). A fresh divide afterwards returns a correct result.
- Random round trip, wI=64, 200000 ops:
  - Randomize X and Y!=0, drive iO=karat_mult(X,Y) -> oQ==X, oR==0, oOvf==0.
  - Randomize iO and iY -> check against a golden model using the / and % operators, including the overflow rule.

Source files
------------

// File: rtl/karat_div_if.sv
// Operand/result handshake bundle for karat_div.
// Signal names keep the divider's port naming; the master drives operands and accepts results.
interface karat_div_if #(
  parameter int unsigned wI = 64
);
  localparam int unsigned WO = 2 * wI;

  logic          iValid;
  logic          oReady;
  logic [WO-1:0] iO;
  logic [wI-1:0] iY;
  logic          oValid;
  logic          iReady;
  logic [wI-1:0] oQ;
  logic [wI-1:0] oR;
  logic          oOvf;

  modport master (
    output iValid, iO, iY, iReady,
    input  oReady, oValid, oQ, oR, oOvf
  );

  modport slave (
    input  iValid, iO, iY, iReady,
    output oReady, oValid, oQ, oR, oOvf
  );
endinterface

// File: rtl/karat_div.sv
// Radix-2 restoring divider: 2*wI-bit dividend by wI-bit divisor, one quotient bit per clock.
// Quotients that cannot fit in wI bits (including divide-by-zero) are flagged in a single edge.
module karat_div #(
  parameter int unsigned wI = 64
) (
  input  logic          iClk,
  input  logic          iRstN,
  karat_div_if.slave    bus
);
  localparam int unsigned WO = 2 * wI;
  localparam int unsigned CW = $clog2(wI) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [wI:0]   r_p,     w_p_nxt;
  logic [wI-1:0] r_s,     w_s_nxt;
  logic [wI-1:0] r_y,     w_y_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [wI-1:0] r_q,     w_q_nxt;
  logic [wI-1:0] r_r,     w_r_nxt;
  logic          r_ovf,   w_ovf_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_ready, w_ready_nxt;

  logic [wI:0]   w_t;
  logic [wI:0]   w_diff;
  logic          w_ge;
  logic [wI:0]   w_p_step;
  logic [wI-1:0] w_s_step;
  logic          w_ovf_in;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  assign w_t      = {r_p[wI-1:0], r_s[wI-1]};
  assign w_diff   = w_t - {1'b0, r_y};
  assign w_ge     = (w_t >= {1'b0, r_y});
  assign w_p_step = w_ge ? w_diff : w_t;
  assign w_s_step = {r_s[wI-2:0], w_ge};

  // Quotient fits in wI bits only when the upper dividend half is below the divisor.
  assign w_ovf_in = (bus.iY == '0) || (bus.iO[WO-1:wI] >= bus.iY);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_s     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_s     <= w_s_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= w_valid_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_s_nxt     = r_s;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_ovf_nxt   = r_ovf;
    w_valid_nxt = r_valid;
    w_ready_nxt = r_ready;

    case (r_state)
      S_IDLE: begin
        if (bus.iValid) begin
          w_y_nxt     = bus.iY;
          w_ready_nxt = 1'b0;
          if (w_ovf_in) begin
            w_q_nxt     = '1;
            w_r_nxt     = '0;
            w_ovf_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_p_nxt     = {1'b0, bus.iO[WO-1:wI]};
            w_s_nxt     = bus.iO[wI-1:0];
            w_cnt_nxt   = '0;
            w_state_nxt = S_CALC;
          end
        end
      end

      S_CALC: begin
        w_p_nxt   = w_p_step;
        w_s_nxt   = w_s_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(wI - 1)) begin
          w_q_nxt     = w_s_step;
          w_r_nxt     = w_p_step[wI-1:0];
          w_ovf_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.iReady) begin
          w_valid_nxt = 1'b0;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_valid_nxt = 1'b0;
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.oReady = r_ready;
  assign bus.oValid = r_valid;
  assign bus.oQ     = r_q;
  assign bus.oR     = r_r;
  assign bus.oOvf   = r_ovf;

endmodule
